// File: rtl/sort_drain.sv
// sort_drain: reads the sorted memory from address 0 to n-1 after the sorter goes idle,
// streams each word out on a valid/ready port and checks the order in-line.
// The check gives a pass/fail flag and a count of inversions, where an inversion is an adjacent pair with prev > curr.
// Latency: start -> mem_ren 1 cycle, -> first out_valid 3 cycles. One word per 3 cycles at out_ready=1.
// Backpressure: while out_ready=0 the word is held on out_data and no new read is issued.
//
// Ports:
//   c_clk, rst      clock, synchronous active-high reset
//   start, n        begin a drain of n words (n clamped to memory depth); start sampled only when idle
//   mem_addr/ren    read request to the shared single-port sort memory
//   mem_rdata       registered RAM data, valid the cycle after mem_ren
//   out_data/valid/ready   streamed word
//   busy, done      busy outside idle; done is a one-cycle completion pulse
//   sorted_ok, inversions  order-check result, held until the next accepted start
module sort_drain #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 c_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] n,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic                 mem_ren,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 sorted_ok,
    output logic [DATAWIDTH-1:0] inversions
);

    localparam int DEPTH = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] DEPTH_CNT = {1'b1, {ADDRWIDTH{1'b0}}};

    // S_ZERO holds one cycle for an empty drain so that done falls two cycles after start.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t               state;
    // idx has one extra bit so a full-depth drain ends at DEPTH without wrapping to 0
    logic [ADDRWIDTH:0]   idx;
    logic [ADDRWIDTH:0]   n_lat;
    logic [ADDRWIDTH:0]   n_clamp;
    logic [ADDRWIDTH:0]   idx_next;
    logic [DATAWIDTH-1:0] prev;
    logic                 have_prev;   // prev holds a word from this drain

    always_comb begin
        n_clamp = n[ADDRWIDTH:0];
        if (n > DATAWIDTH'(DEPTH)) begin
            n_clamp = DEPTH_CNT;
        end
    end

    assign idx_next = idx + 1'b1;

    always_ff @(posedge c_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            n_lat      <= '0;
            prev       <= '0;
            have_prev  <= 1'b0;
            out_data   <= '0;
            sorted_ok  <= 1'b1;
            inversions <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat      <= n_clamp;
                        idx        <= '0;
                        inversions <= '0;
                        have_prev  <= 1'b0;
                        sorted_ok  <= 1'b1;
                        state      <= (n_clamp == '0) ? S_ZERO : S_READ;
                    end
                end
                S_ZERO: begin
                    state <= S_DONE;
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    out_data <= mem_rdata;
                    if (have_prev && (prev > mem_rdata)) begin
                        if (inversions != {DATAWIDTH{1'b1}}) begin
                            inversions <= inversions + 1'b1;
                        end
                        sorted_ok <= 1'b0;
                    end
                    prev      <= mem_rdata;
                    have_prev <= 1'b1;
                    state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        idx   <= idx_next;
                        state <= (idx_next == n_lat) ? S_DONE : S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs come from registers only; none depends combinationally on an input.
    assign mem_ren   = (state == S_READ);
    assign mem_addr  = idx[ADDRWIDTH-1:0];
    assign out_valid = (state == S_PRESENT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule
